stack_mc: RTL and testbench
===========================

STACK_MC -- requirements
Module: stack_mc

Interface
REQ-001 Parameter NCH, default 4, number of independent stacks (>=1).
REQ-002 Parameter DEPTH, default 64, entries per stack (power of 2, >=2).
REQ-003 Parameter DWID, default 16, data width.
REQ-004 Parameter AFULL, default 60, almost-full threshold in entries (1..DEPTH).
REQ-005 Derived: CWID = max(1,$clog2(NCH)); AWID = $clog2(DEPTH); NWID = AWID+1.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ch  input  CWID  channel select for this cycle's operation and status.
REQ-009 push  input  1  push din onto stack ch.
REQ-010 pop  input  1  pop top of stack ch.
REQ-011 clr  input  1  empty stack ch.
REQ-012 err_clr  input  1  clear all sticky error flags.
REQ-013 din  input  DWID  push data.
REQ-014 dout  output  DWID  popped data, registered.
REQ-015 dout_v  output  1  dout valid strobe, one cycle per pop.
REQ-016 dout_ch  output  CWID  channel dout came from.
REQ-017 cnt  output  NWID  occupancy of stack ch, combinational from ch.
REQ-018 empty, full, afull  output  1 each  cnt==0, cnt==DEPTH, cnt>=AFULL for stack ch.
REQ-019 ovf, udf  output  NCH each  sticky overflow / underflow flag per channel.

Function
REQ-020 Storage SHALL be one NCH*DEPTH x DWID array, stack c at addresses {c, ptr}, with a 1-cycle synchronous read.
REQ-021 Each channel SHALL keep its own NWID-bit count; ptr of top entry = count-1.
REQ-022 Operation priority per cycle, on channel ch only: clr > push&pop > push > pop.
REQ-023 clr: count[ch] <- 0 next edge; push/pop ignored; no dout_v; flags unaffected.
REQ-024 push only, count<DEPTH: write din at {ch,count}, count+1.
REQ-025 push only, count==DEPTH: no write, count unchanged, ovf[ch] <- 1.
REQ-026 pop only, count>0: read {ch,count-1}, count-1; next cycle dout=that entry, dout_v=1, dout_ch=ch.
REQ-027 pop only, count==0: count unchanged, udf[ch] <- 1, dout_v=0 next cycle.
REQ-028 push&pop (any count incl. 0 or DEPTH): pass-through; no array write, count unchanged; next cycle dout=din, dout_v=1, dout_ch=ch; no flag set.
REQ-029 Pop latency SHALL be exactly 1 cycle; back-to-back pops on any channel mix SHALL yield one dout_v per cycle.
REQ-030 Push then pop of same channel on consecutive cycles SHALL return the just-pushed value (write-before-read ordering).
REQ-031 dout/dout_ch SHALL hold last value when dout_v=0.
REQ-032 Channels other than ch SHALL be unchanged in any cycle.
REQ-033 err_clr clears all ovf/udf bits next edge; a new error on the same edge SHALL win (bit set).
REQ-034 No count SHALL ever wrap below 0 or above DEPTH.
REQ-035 ch >= NCH (NCH not power of 2): operation ignored, cnt/empty/full/afull report 0/1/0/0.

Reset
REQ-036 On rst: all counts 0, dout 0, dout_v 0, dout_ch 0, ovf 0, udf 0; array contents undefined and unobservable.
REQ-037 rst asserted mid-operation SHALL abort any pending pop (dout_v 0 at first edge after release).
REQ-038 First operation SHALL be accepted on first rising edge after rst deasserts.

Verification
REQ-039 Push 0x0001..0x0040 to ch0 (DEPTH=64) -> full=1, afull=1 from cnt 60; 65th push -> ovf=4'b0001, cnt=64.
REQ-040 Then 64 pops ch0 -> dout 0x0040 down to 0x0001, one per cycle, dout_v continuous; 65th pop -> udf=4'b0001, dout_v=0.
REQ-041 Push 0xAAAA ch1, 0xBBBB ch2, pop ch1, pop ch2 consecutively -> dout 0xAAAA (dout_ch=1) then 0xBBBB (dout_ch=2); ch0/ch3 cnt stay 0.
REQ-042 push&pop ch3 with din=0x1234 while empty -> next cycle dout=0x1234, dout_v=1, cnt stays 0, udf[3]=0.
REQ-043 Fill ch0 to 10, assert clr+push same cycle -> cnt=0, no write; err_clr with simultaneous empty pop ch2 -> udf=4'b0100 only.
REQ-044 Assert rst during pop of ch0 with cnt=5 -> dout_v=0, cnt=0, flags 0 after release.

Source files
------------

// File: rtl/stack_mc.sv
// Multi-channel LIFO: NCH independent stacks sharing one storage array,
// with per-channel occupancy, sticky overflow/underflow flags and registered pop data.
module stack_mc #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DWID  = 16,
    parameter int unsigned AFULL = 60,
    localparam int unsigned CWID = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned AWID = $clog2(DEPTH),
    localparam int unsigned NWID = AWID + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CWID-1:0] ch,
    input  logic            push,
    input  logic            pop,
    input  logic            clr,
    input  logic            err_clr,
    input  logic [DWID-1:0] din,
    output logic [DWID-1:0] dout,
    output logic            dout_v,
    output logic [CWID-1:0] dout_ch,
    output logic [NWID-1:0] cnt,
    output logic            empty,
    output logic            full,
    output logic            afull,
    output logic [NCH-1:0]  ovf,
    output logic [NCH-1:0]  udf
);

    logic [NWID-1:0] count [NCH];
    logic [DWID-1:0] mem   [NCH*DEPTH];

    logic            ch_ok;
    logic [CWID-1:0] ch_idx;
    logic [NWID-1:0] cur_cnt;
    logic            is_empty;
    logic            is_full;
    logic            do_push;
    logic            do_pop;
    logic            do_clr;
    logic            do_pp;
    logic            wr_en;
    logic            rd_en;
    logic [AWID-1:0] wr_ptr;
    logic [AWID-1:0] rd_ptr;
    logic [NCH-1:0]  ovf_nxt;
    logic [NCH-1:0]  udf_nxt;

    // Channel decode; an out-of-range channel selects nothing and reads as empty
    always_comb begin
        ch_ok    = (32'(ch) < NCH);
        ch_idx   = ch_ok ? ch : '0;
        cur_cnt  = count[ch_idx];
        is_empty = (cur_cnt == '0);
        is_full  = (cur_cnt == NWID'(DEPTH));
        wr_ptr   = cur_cnt[AWID-1:0];
        rd_ptr   = AWID'(cur_cnt - NWID'(1));
    end

    assign cnt   = ch_ok ? cur_cnt : '0;
    assign empty = ch_ok ? is_empty : 1'b1;
    assign full  = ch_ok & is_full;
    assign afull = ch_ok & (cur_cnt >= NWID'(AFULL));

    // Operation priority: clr, then push&pop pass-through, then push, then pop
    always_comb begin
        do_clr  = ch_ok & clr;
        do_pp   = ch_ok & ~clr & push & pop;
        do_push = ch_ok & ~clr & push & ~pop;
        do_pop  = ch_ok & ~clr & pop & ~push;
        wr_en   = do_push & ~is_full;
        rd_en   = do_pop & ~is_empty;
    end

    // New errors on the same edge as err_clr take precedence
    always_comb begin
        ovf_nxt = err_clr ? '0 : ovf;
        udf_nxt = err_clr ? '0 : udf;
        if (do_push && is_full) begin
            ovf_nxt[ch_idx] = 1'b1;
        end
        if (do_pop && is_empty) begin
            udf_nxt[ch_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{ch_idx, wr_ptr}] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                count[i] <= '0;
            end
        end else if (do_clr) begin
            count[ch_idx] <= '0;
        end else if (wr_en) begin
            count[ch_idx] <= cur_cnt + NWID'(1);
        end else if (rd_en) begin
            count[ch_idx] <= cur_cnt - NWID'(1);
        end
    end

    // Pop data path: dout/dout_ch hold their last value between pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            dout_v  <= 1'b0;
            dout_ch <= '0;
            ovf     <= '0;
            udf     <= '0;
        end else begin
            dout_v <= rd_en | do_pp;
            ovf    <= ovf_nxt;
            udf    <= udf_nxt;
            if (rd_en || do_pp) begin
                dout    <= do_pp ? din : mem[{ch_idx, rd_ptr}];
                dout_ch <= ch_idx;
            end
        end
    end

endmodule

// File: tb/tb_stack_mc.sv
// Self-checking bench for stack_mc: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_stack_mc;

    logic        clk;
    logic        rst;
    logic [1:0]  ch;
    logic        push;
    logic        pop;
    logic        clr;
    logic        err_clr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_v;
    logic [1:0]  dout_ch;
    logic [6:0]  cnt;
    logic        empty;
    logic        full;
    logic        afull;
    logic [3:0]  ovf;
    logic [3:0]  udf;

    int tests;
    int fails;
    logic chk_en;

    // Reference model: one queue per channel, top of stack at the back
    logic [15:0] stk [4][$];
    logic [15:0] e_dout;
    logic        e_v;
    logic [1:0]  e_ch;
    logic [3:0]  e_ovf;
    logic [3:0]  e_udf;

    stack_mc #(.NCH(4), .DEPTH(64), .DWID(16), .AFULL(60)) dut (
        .clk(clk), .rst(rst), .ch(ch), .push(push), .pop(pop), .clr(clr),
        .err_clr(err_clr), .din(din), .dout(dout), .dout_v(dout_v),
        .dout_ch(dout_ch), .cnt(cnt), .empty(empty), .full(full),
        .afull(afull), .ovf(ovf), .udf(udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) stk[i].delete();
        e_dout = '0;
        e_v    = 1'b0;
        e_ch   = '0;
        e_ovf  = '0;
        e_udf  = '0;
    endtask

    task automatic model_step();
        int c;
        logic [3:0] so;
        logic [3:0] su;
        c  = int'(ch);
        so = '0;
        su = '0;
        e_v = 1'b0;
        if (clr) begin
            stk[c].delete();
        end else if (push && pop) begin
            e_dout = din;
            e_v    = 1'b1;
            e_ch   = ch;
        end else if (push) begin
            if (stk[c].size() == 64) so[c] = 1'b1;
            else stk[c].push_back(din);
        end else if (pop) begin
            if (stk[c].size() == 0) begin
                su[c] = 1'b1;
            end else begin
                e_dout = stk[c].pop_back();
                e_v    = 1'b1;
                e_ch   = ch;
            end
        end
        e_ovf = (err_clr ? 4'b0 : e_ovf) | so;
        e_udf = (err_clr ? 4'b0 : e_udf) | su;
    endtask

    task automatic op(input logic [1:0] c, input logic pu, input logic po,
                      input logic cl, input logic ec, input logic [15:0] d);
        ch = c; push = pu; pop = po; clr = cl; err_clr = ec; din = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic [1:0] c);
        op(c, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = stk[ch].size();
            chk("cnt", 32'(cnt), 32'(n));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("full", 32'(full), 32'(n == 64));
            chk("afull", 32'(afull), 32'(n >= 60));
            chk("dout_v", 32'(dout_v), 32'(e_v));
            chk("dout", 32'(dout), 32'(e_dout));
            chk("dout_ch", 32'(dout_ch), 32'(e_ch));
            chk("ovf", 32'(ovf), 32'(e_ovf));
            chk("udf", 32'(udf), 32'(e_udf));
        end
    end

    initial begin
        tests = 0; fails = 0; chk_en = 1'b0;
        ch = '0; push = 0; pop = 0; clr = 0; err_clr = 0; din = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dout_v", 32'(dout_v), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_flags", 32'({ovf, udf}), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Fill ch0, threshold and full boundaries, then overflow
        for (int i = 1; i <= 64; i++) begin
            op(2'd0, 1, 0, 0, 0, 16'(i));
            if (i == 59) chk("afull_59", 32'(afull), 32'h0);
            if (i == 60) chk("afull_60", 32'({cnt, afull}), {24'h0, 7'd60, 1'b1});
            if (i == 63) chk("full_63", 32'(full), 32'h0);
        end
        chk("full_64", 32'(full), 32'h1);
        op(2'd0, 1, 0, 0, 0, 16'h0041);
        chk("ovf_65", 32'(ovf), 32'h1);
        chk("cnt_65", 32'(cnt), 32'd64);

        // Drain ch0 with continuous pops, then underflow
        for (int i = 1; i <= 64; i++) begin
            op(2'd0, 0, 1, 0, 0, 16'h0);
            chk("pop_dout", 32'(dout), 32'(65 - i));
            chk("pop_v", 32'(dout_v), 32'h1);
        end
        op(2'd0, 0, 1, 0, 0, 16'h0);
        chk("udf_65", 32'(udf), 32'h1);
        chk("udf_v", 32'(dout_v), 32'h0);
        chk("hold_dout", 32'(dout), 32'h1);

        // Two channels interleaved
        op(2'd1, 1, 0, 0, 0, 16'hAAAA);
        op(2'd2, 1, 0, 0, 0, 16'hBBBB);
        op(2'd1, 0, 1, 0, 0, 16'h0);
        chk("ch1_pop", 32'({dout_ch, dout}), {14'h0, 2'd1, 16'hAAAA});
        op(2'd2, 0, 1, 0, 0, 16'h0);
        chk("ch2_pop", 32'({dout_ch, dout}), {14'h0, 2'd2, 16'hBBBB});
        idle(2'd0);
        chk("ch0_cnt", 32'(cnt), 32'h0);
        idle(2'd3);
        chk("ch3_cnt", 32'(cnt), 32'h0);

        // Pass-through on an empty stack
        op(2'd3, 1, 1, 0, 0, 16'h1234);
        chk("pp_dout", 32'({dout_v, dout}), {15'h0, 1'b1, 16'h1234});
        chk("pp_cnt", 32'(cnt), 32'h0);
        chk("pp_udf3", 32'(udf[3]), 32'h0);

        // Push immediately followed by pop of the same channel
        op(2'd1, 1, 0, 0, 0, 16'h5555);
        op(2'd1, 0, 1, 0, 0, 16'h0);
        chk("wr_rd", 32'(dout), 32'h5555);

        // clr beats push; err_clr with a simultaneous new underflow
        for (int i = 0; i < 10; i++) op(2'd0, 1, 0, 0, 0, 16'(16'h100 + i));
        chk("cnt_10", 32'(cnt), 32'd10);
        op(2'd0, 1, 0, 1, 0, 16'hDEAD);
        chk("clr_cnt", 32'(cnt), 32'h0);
        op(2'd2, 0, 1, 0, 1, 16'h0);
        chk("errclr_udf", 32'(udf), 32'h4);
        chk("errclr_ovf", 32'(ovf), 32'h0);

        // Reset in the middle of a pop
        for (int i = 0; i < 5; i++) op(2'd0, 1, 0, 0, 0, 16'(16'h200 + i));
        ch = 2'd0; push = 0; pop = 1; clr = 0; err_clr = 0;
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        pop = 0;
        rst = 1'b0;
        chk("rstpop_v", 32'(dout_v), 32'h0);
        chk("rstpop_cnt", 32'(cnt), 32'h0);
        chk("rstpop_flags", 32'({ovf, udf}), 32'h0);

        // First edge after release accepts an operation
        op(2'd2, 1, 0, 0, 0, 16'h0077);
        chk("first_v", 32'(dout_v), 32'h0);
        op(2'd2, 0, 1, 0, 0, 16'h0);
        chk("first_pop", 32'(dout), 32'h0077);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 300; i++) begin
            op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
               16'($urandom));
        end
        idle(2'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
